apb_uart_bridge: RTL and testbench
==================================

APB_UART_BRIDGE -- requirements
Module: apb_uart_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: PCLK, PRESET.
REQ-002 Parameter WAIT_STATES, default 1, SHALL set the number of ACCESS cycles with PREADY low before completion (range 0..7).
REQ-003 Parameter ADDR_BASE, default 32'h0000_0000, SHALL be the base address of the register window.
REQ-004 PCLK  input  1  APB clock; all state changes on its rising edge.
REQ-005 PRESET  input  1  asynchronous active-high reset.
REQ-006 PSEL  input  1  APB select.
REQ-007 PENABLE  input  1  APB enable (ACCESS phase).
REQ-008 PWRITE  input  1  1 = write, 0 = read.
REQ-009 PADDR  input  32  byte address.
REQ-010 PWDATA  input  32  write data; bits [7:0] used.
REQ-011 PRDATA  output  32  read data, registered.
REQ-012 PREADY  output  1  transfer completion.
REQ-013 PSLVERR  output  1  error; valid only while PREADY=1.
REQ-014 wr_uart  output  1  one-cycle push strobe to the UART TX FIFO.
REQ-015 w_data  output  8  TX byte, valid while wr_uart=1.
REQ-016 rd_uart  output  1  one-cycle pop strobe to the UART RX FIFO.
REQ-017 r_data  input  8  head of the RX FIFO (first-word fall-through).
REQ-018 tx_full  input  1  TX FIFO full.
REQ-019 rx_empty  input  1  RX FIFO empty.

Function
REQ-020 The register map, offsets from ADDR_BASE, SHALL be: 0x0 TXDATA (write-only), 0x4 RXDATA (read-only), 0x8 STATUS (read-only: bit0 = rx_empty, bit1 = tx_full, other bits 0), 0xC IRQ_EN (see Configuration).
REQ-021 The FSM SHALL have the states IDLE, SETUP and ACCESS.
REQ-022 IDLE->SETUP SHALL occur on PSEL=1 with PENABLE=0.
REQ-023 SETUP->ACCESS SHALL occur on the next cycle; a wait counter SHALL be cleared on entry to ACCESS.
REQ-024 In ACCESS, PREADY SHALL be driven high when the wait counter equals WAIT_STATES; with WAIT_STATES=0 this is the first ACCESS cycle.
REQ-025 After the PREADY cycle the FSM SHALL return to SETUP if PSEL=1 and PENABLE=0 (back-to-back transfer), otherwise to IDLE.
REQ-026 If PSEL goes low in ACCESS before PREADY, the FSM SHALL return to IDLE with no strobe and no register change.
REQ-027 Write to TXDATA with tx_full=0 SHALL pulse wr_uart in the PREADY cycle, with w_data = PWDATA[7:0].
REQ-028 Write to TXDATA with tx_full=1 (sampled in the PREADY cycle) SHALL complete with PSLVERR=1 and SHALL NOT pulse wr_uart.
REQ-029 Read of RXDATA with rx_empty=0 SHALL pulse rd_uart in the PREADY cycle and return {24'b0, r_data} on PRDATA.
REQ-030 Read of RXDATA with rx_empty=1 SHALL complete with PSLVERR=1, PRDATA=0 and no rd_uart pulse.
REQ-031 Each of the following SHALL complete normally with PSLVERR=1 and no side effect: an unmapped offset, an unaligned address (PADDR[1:0]!=0), a write to RXDATA or STATUS, or a read of TXDATA.
REQ-032 Each accepted transfer SHALL produce at most one strobe, and wr_uart and rd_uart SHALL never be high together.
REQ-033 PRDATA SHALL hold its value until the next read completes; writes SHALL NOT alter PRDATA.

Reset
REQ-034 While PRESET=1 the FSM SHALL be IDLE; PRDATA, PREADY, PSLVERR, wr_uart, rd_uart, w_data, the wait counter and IRQ_EN SHALL all be 0.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer immediately, with no strobe issued.
REQ-036 Operation SHALL resume on the first rising edge of PCLK after PRESET deasserts.

Configuration
REQ-037 With macro UART_BRIDGE_IRQ_EN defined, the block SHALL include IRQ_EN at 0xC (read/write, bits[1:0]), and it SHALL add output irq (1 bit, registered) = (IRQ_EN[0] & ~rx_empty) | (IRQ_EN[1] & ~tx_full).
REQ-038 Without UART_BRIDGE_IRQ_EN, the irq port SHALL be absent and offset 0xC SHALL behave as unmapped (PSLVERR=1).

Verification
REQ-039 Write 0x41 to 0x0 with tx_full=0 and WAIT_STATES=1 -> PREADY high in the 2nd ACCESS cycle, wr_uart pulses once, w_data=0x41, PSLVERR=0.
REQ-040 Read 0x4 with r_data=0x5A and rx_empty=0 -> PRDATA=0x0000005A, one rd_uart pulse; then repeat with rx_empty=1 -> PSLVERR=1, PRDATA=0, no pulse.
REQ-041 Write to 0x0 with tx_full=1 -> PSLVERR=1, no wr_uart pulse; then read 0x8 -> PRDATA=0x2 when rx_empty=0.
REQ-042 Access 0x10 and 0x2 -> PSLVERR=1 with no strobes; access 0xC without UART_BRIDGE_IRQ_EN -> PSLVERR=1.
REQ-043 Assert PRESET in ACCESS before PREADY -> all outputs 0 within the same cycle, no strobe; back-to-back writes after release -> two wr_uart pulses.
REQ-044 With UART_BRIDGE_IRQ_EN defined, write 0x1 to 0xC, then drive rx_empty 1->0 -> irq rises one cycle later.

Source files
------------

// File: rtl/apb_uart_bridge.sv
// APB slave that maps TXDATA/RXDATA/STATUS onto UART FIFO push/pop strobes.
// Optional IRQ_EN register and irq output are built when UART_BRIDGE_IRQ_EN is defined.
module apb_uart_bridge #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        wr_uart,
    output logic [7:0]  w_data,
    output logic        rd_uart,
    input  logic [7:0]  r_data,
    input  logic        tx_full,
`ifdef UART_BRIDGE_IRQ_EN
    output logic        irq,
`endif
    input  logic        rx_empty
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2} state_t;

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        w_complete;
    logic [31:0] w_off;
    logic        w_err;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_rdata;
    logic [31:0] r_prdata;
    logic        r_pready;
    logic        r_pslverr;
    logic        r_wr;
    logic [7:0]  r_wdata;
    logic        r_rd;
    logic        w_unused_pwdata;
`ifdef UART_BRIDGE_IRQ_EN
    logic        w_irq_we;
    logic [1:0]  r_irq_en;
    logic        r_irq;
`endif

    assign w_unused_pwdata = ^PWDATA[31:8];

    // Next-state and wait-counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
                w_cnt_nxt   = 3'd0;
            end
            S_ACCESS: begin
                if (r_cnt == WS) begin
                    w_state_nxt = (PSEL && !PENABLE) ? S_SETUP : S_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else if (!PSEL) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
        // Outputs are registered, so the completion cycle is decided one edge ahead
        w_complete = (w_state_nxt == S_ACCESS) && (w_cnt_nxt == WS);
    end

    // Register-map decode of the current transfer
    always_comb begin
        w_off   = PADDR - ADDR_BASE;
        w_err   = 1'b0;
        w_wr    = 1'b0;
        w_rd    = 1'b0;
        w_rdata = 32'h0000_0000;
`ifdef UART_BRIDGE_IRQ_EN
        w_irq_we = 1'b0;
`endif
        if ((w_off[1:0] != 2'b00) || (w_off[31:4] != 28'h0000000)) begin
            w_err = 1'b1;
        end else begin
            case (w_off[3:2])
                2'd0: begin
                    if (PWRITE && !tx_full) begin
                        w_wr = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                2'd1: begin
                    if (!PWRITE && !rx_empty) begin
                        w_rd    = 1'b1;
                        w_rdata = {24'h000000, r_data};
                    end else begin
                        w_err = 1'b1;
                    end
                end
                2'd2: begin
                    if (!PWRITE) begin
                        w_rdata = {30'h00000000, tx_full, rx_empty};
                    end else begin
                        w_err = 1'b1;
                    end
                end
                2'd3: begin
`ifdef UART_BRIDGE_IRQ_EN
                    if (PWRITE) begin
                        w_irq_we = 1'b1;
                    end else begin
                        w_rdata = {30'h00000000, r_irq_en};
                    end
`else
                    w_err = 1'b1;
`endif
                end
                default: begin
                    w_err = 1'b1;
                end
            endcase
        end
    end

    // FSM state and wait counter
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered APB response and FIFO strobes
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_prdata  <= 32'h0000_0000;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_wr      <= 1'b0;
            r_wdata   <= 8'h00;
            r_rd      <= 1'b0;
        end else begin
            r_pready  <= w_complete;
            r_pslverr <= w_complete && w_err;
            r_wr      <= w_complete && w_wr;
            r_wdata   <= (w_complete && w_wr) ? PWDATA[7:0] : 8'h00;
            r_rd      <= w_complete && w_rd;
            if (w_complete && !PWRITE) begin
                r_prdata <= w_rdata;
            end else begin
                r_prdata <= r_prdata;
            end
        end
    end

`ifdef UART_BRIDGE_IRQ_EN
    // Interrupt enable register and registered interrupt request
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_irq_en <= 2'b00;
            r_irq    <= 1'b0;
        end else begin
            if (w_complete && w_irq_we) begin
                r_irq_en <= PWDATA[1:0];
            end else begin
                r_irq_en <= r_irq_en;
            end
            r_irq <= (r_irq_en[0] & ~rx_empty) | (r_irq_en[1] & ~tx_full);
        end
    end

    assign irq = r_irq;
`endif

    assign PRDATA  = r_prdata;
    assign PREADY  = r_pready;
    assign PSLVERR = r_pslverr;
    assign wr_uart = r_wr;
    assign w_data  = r_wdata;
    assign rd_uart = r_rd;
endmodule

// File: tb/tb_apb_uart_bridge.sv
// Scoreboard bench for apb_uart_bridge: a task-driven APB master pushes predicted
// responses, and a negedge monitor checks them whenever PREADY is high.
module tb_apb_uart_bridge;
    localparam int unsigned WS   = 1;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        rd_uart;
    logic [7:0]  r_data;
    logic        tx_full;
    logic        rx_empty;
`ifdef UART_BRIDGE_IRQ_EN
    logic        irq;
`endif

    apb_uart_bridge #(.WAIT_STATES(WS), .ADDR_BASE(BASE)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .wr_uart(wr_uart), .w_data(w_data),
        .rd_uart(rd_uart), .r_data(r_data), .tx_full(tx_full),
`ifdef UART_BRIDGE_IRQ_EN
        .irq(irq),
`endif
        .rx_empty(rx_empty)
    );

    typedef struct {
        bit          err;
        bit          wr;
        bit [7:0]    wdata;
        bit          rd;
        logic [31:0] prdata;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_cnt   = 0;
    int          rd_cnt   = 0;
    logic [31:0] m_prdata = 32'h0;
    logic [1:0]  m_irq_en = 2'b00;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: register map evaluated from the current FIFO flags
    task automatic predict(input bit wr, input logic [31:0] a, input logic [31:0] d, output exp_t e);
        logic [31:0] off;
        logic [31:0] rd_val;
        off    = a - BASE;
        rd_val = 32'h0;
        e      = '{err: 1'b0, wr: 1'b0, wdata: 8'h00, rd: 1'b0, prdata: 32'h0};
        if (off == 32'h0 && wr) begin
            if (tx_full) e.err = 1'b1;
            else begin e.wr = 1'b1; e.wdata = d[7:0]; end
        end else if (off == 32'h4 && !wr) begin
            if (rx_empty) e.err = 1'b1;
            else begin e.rd = 1'b1; rd_val = {24'h0, r_data}; end
        end else if (off == 32'h8 && !wr) begin
            rd_val = {30'h0, tx_full, rx_empty};
`ifdef UART_BRIDGE_IRQ_EN
        end else if (off == 32'hC) begin
            if (wr) m_irq_en = d[1:0];
            else rd_val = {30'h0, m_irq_en};
`endif
        end else begin
            e.err = 1'b1;
        end
        if (!wr) m_prdata = rd_val;
        e.prdata = m_prdata;
    endtask

    // One APB transfer; returns on the negedge at which PREADY is seen
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   k;
        predict(wr, a, d, e);
        expq.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        k = 0;
        do begin
            @(negedge PCLK);
            k++;
        end while (!PREADY && k <= 20);
        // FSM lags the master by one cycle, then SETUP, then WS+1 ACCESS cycles
        check("latency", k, WS + 2);
    endtask

    task automatic idle();
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Monitor: strobe sanity every cycle, scoreboard pop on each completion
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (wr_uart || rd_uart) begin
                check("strobe_with_pready", PREADY, 1);
                check("strobe_exclusive", wr_uart & rd_uart, 0);
            end
            if (wr_uart) wr_cnt++;
            if (rd_uart) rd_cnt++;
            if (PREADY) begin
                if (expq.size() == 0) begin
                    check("unexpected_pready", PREADY, 0);
                end else begin
                    mon_e = expq.pop_front();
                    check("pslverr", PSLVERR, mon_e.err);
                    check("prdata", PRDATA, mon_e.prdata);
                    check("wr_uart", wr_uart, mon_e.wr);
                    check("rd_uart", rd_uart, mon_e.rd);
                    if (mon_e.wr) check("w_data", w_data, mon_e.wdata);
                end
            end
        end
    end

    logic [31:0] addr_tab [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h2, 32'h5, 32'h100};

    initial begin
        int w0;
        int r0;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0; r_data = 8'h00; tx_full = 1'b0; rx_empty = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_pready", PREADY, 0);
        check("rst_pslverr", PSLVERR, 0);
        check("rst_wr_uart", wr_uart, 0);
        check("rst_rd_uart", rd_uart, 0);
        check("rst_w_data", w_data, 8'h00);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Basic TX write with one wait state
        w0 = wr_cnt;
        tx_full = 1'b0;
        xfer(1'b1, BASE + 32'h0, 32'h0000_0041);
        idle();
        check("tx_one_pulse", wr_cnt - w0, 1);

        // RX read, then read again with RX FIFO empty
        r0 = rd_cnt;
        rx_empty = 1'b0; r_data = 8'h5A;
        xfer(1'b0, BASE + 32'h4, 32'h0);
        idle();
        rx_empty = 1'b1;
        xfer(1'b0, BASE + 32'h4, 32'h0);
        idle();
        check("rx_one_pulse", rd_cnt - r0, 1);

        // TX FIFO full, then STATUS
        w0 = wr_cnt;
        tx_full = 1'b1; rx_empty = 1'b0;
        xfer(1'b1, BASE + 32'h0, 32'h0000_00AA);
        xfer(1'b0, BASE + 32'h8, 32'h0);
        idle();
        check("txfull_no_pulse", wr_cnt - w0, 0);

        // Unmapped, unaligned and IRQ_EN offsets
        tx_full = 1'b0;
        xfer(1'b1, BASE + 32'h10, 32'h0000_0033);
        xfer(1'b0, BASE + 32'h2, 32'h0);
        xfer(1'b0, BASE + 32'hC, 32'h0);
        idle();

        // Master abandons the transfer before PREADY
        w0 = wr_cnt;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = BASE; PWDATA = 32'h99;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (4) @(posedge PCLK);
        #1;
        check("psel_abort_no_strobe", wr_cnt - w0, 0);

        // Reset during ACCESS wait: PRDATA preloaded non-zero first
        rx_empty = 1'b0; r_data = 8'hA5;
        xfer(1'b0, BASE + 32'h4, 32'h0);
        idle();
        w0 = wr_cnt;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = BASE; PWDATA = 32'h77;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #2;
        PRESET = 1'b1;
        #1;
        check("abort_rst_prdata", PRDATA, 32'h0);
        check("abort_rst_pready", PREADY, 0);
        check("abort_rst_pslverr", PSLVERR, 0);
        check("abort_rst_wr", wr_uart, 0);
        check("abort_rst_rd", rd_uart, 0);
        m_prdata = 32'h0;
        m_irq_en = 2'b00;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        check("abort_rst_no_strobe", wr_cnt - w0, 0);

        // Back-to-back writes after reset release
        w0 = wr_cnt;
        tx_full = 1'b0;
        xfer(1'b1, BASE, 32'h11);
        xfer(1'b1, BASE, 32'h22);
        idle();
        check("b2b_two_pulses", wr_cnt - w0, 2);

`ifdef UART_BRIDGE_IRQ_EN
        // IRQ on RX not-empty
        tx_full = 1'b1; rx_empty = 1'b1;
        xfer(1'b1, BASE + 32'hC, 32'h1);
        idle();
        repeat (2) @(posedge PCLK);
        #1;
        rx_empty = 1'b0;
        @(negedge PCLK);
        check("irq_not_yet", irq, 0);
        @(negedge PCLK);
        check("irq_rise", irq, 1);
        xfer(1'b0, BASE + 32'hC, 32'h0);
        idle();
`endif

        // Randomised traffic
        for (int i = 0; i < 80; i++) begin
            tx_full  = ($urandom_range(3, 0) == 0);
            rx_empty = ($urandom_range(3, 0) == 0);
            r_data   = 8'($urandom);
            xfer(1'($urandom), BASE + addr_tab[$urandom_range(7, 0)], $urandom);
            if ($urandom_range(1, 0) == 1) idle();
        end
        idle();
        repeat (4) @(posedge PCLK);
        #1;
        check("queue_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
